// File: rtl/branch_conditional_unit_if.sv
// Issue/result bundle between the B-form decoder, the branch unit and its
// consumers (fetch redirect, completion, mtctr/mtlr paths).
interface branch_conditional_unit_if #(
  parameter int addressWidth            = 64,
  parameter int instructionCounterWidth = 64,
  parameter int opcodeSize              = 6,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3
);
  localparam int bodyWidth = 2 * regSize + immediateSize + 4;

  logic                               enable_i;
  logic                               stall_i;
  logic [opcodeSize-1:0]              instructionOpcode_i;
  logic [addressWidth-1:0]            instructionAddress_i;
  logic [funcUnitCodeSize-1:0]        functionalUnitType_i;
  logic [instructionCounterWidth-1:0] instMajId_i;
  logic                               is64Bit_i;
  logic [0:bodyWidth-1]               instructionBody_i;
  logic [0:31]                        condReg_i;
  logic                               ctrWrite_i;
  logic [addressWidth-1:0]            ctrData_i;
  logic                               lrWrite_i;
  logic [addressWidth-1:0]            lrData_i;

  logic                               busy_o;
  logic                               valid_o;
  logic                               invalid_o;
  logic                               taken_o;
  logic [addressWidth-1:0]            target_o;
  logic [instructionCounterWidth-1:0] instMajId_o;
  logic [addressWidth-1:0]            ctr_o;
  logic [addressWidth-1:0]            lr_o;

  modport master (
    output enable_i, stall_i, instructionOpcode_i, instructionAddress_i,
           functionalUnitType_i, instMajId_i, is64Bit_i, instructionBody_i,
           condReg_i, ctrWrite_i, ctrData_i, lrWrite_i, lrData_i,
    input  busy_o, valid_o, invalid_o, taken_o, target_o, instMajId_o,
           ctr_o, lr_o
  );

  modport slave (
    input  enable_i, stall_i, instructionOpcode_i, instructionAddress_i,
           functionalUnitType_i, instMajId_i, is64Bit_i, instructionBody_i,
           condReg_i, ctrWrite_i, ctrData_i, lrWrite_i, lrData_i,
    output busy_o, valid_o, invalid_o, taken_o, target_o, instMajId_o,
           ctr_o, lr_o
  );
endinterface

// File: rtl/branch_conditional_unit.sv
// Branch Conditional (opcode 16) execution unit: owns architected CTR/LR,
// resolves BO/BI against CR and emits one resolved-branch record per issue.
module branch_conditional_unit #(
  parameter int addressWidth            = 64,
  parameter int instructionCounterWidth = 64,
  parameter int opcodeSize              = 6,
  parameter int regSize                 = 5,
  parameter int immediateSize           = 14,
  parameter int funcUnitCodeSize        = 3,
  parameter int BranchUnitID            = 6
) (
  input logic clock_i,
  input logic reset_i,
  branch_conditional_unit_if.slave bus
);
  localparam int bdWidth = immediateSize + 2;
  localparam int biLo    = regSize;
  localparam int bdLo    = 2 * regSize;
  localparam int aaPos   = bdLo + bdWidth;
  localparam int lkPos   = aaPos + 1;

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;
  state_t state;

  logic [opcodeSize-1:0]              op_q;
  logic [funcUnitCodeSize-1:0]        unit_q;
  logic [addressWidth-1:0]            cia_q;
  logic [instructionCounterWidth-1:0] id_q;
  logic                               mode64_q;
  logic [0:regSize-1]                 bo_q;
  logic [regSize-1:0]                 bi_q;
  logic [bdWidth-1:0]                 bd_q;
  logic                               aa_q;
  logic                               lk_q;
  logic [0:31]                        cr_q;

  logic [addressWidth-1:0] ctr_q, lr_q;
  logic                    ctr_pend, lr_pend;
  logic [addressWidth-1:0] ctr_pend_data, lr_pend_data;

  logic                               busy_q, valid_q, invalid_q, taken_q;
  logic [addressWidth-1:0]            target_q;
  logic [instructionCounterWidth-1:0] id_out_q;

  logic                    rec_ok, ctr_zero, ctr_ok, cond_ok, taken_eval;
  logic                    ctr_upd, lr_upd;
  logic [addressWidth-1:0] exts, cia_next, ctr_eval, nia, target_eval, lr_eval;

  always_comb begin
    rec_ok      = (op_q == opcodeSize'(16)) &&
                  (unit_q == funcUnitCodeSize'(BranchUnitID));
    exts        = {{(addressWidth-bdWidth){bd_q[bdWidth-1]}}, bd_q};
    cia_next    = cia_q + addressWidth'(4);
    ctr_eval    = bo_q[2] ? ctr_q : ctr_q - addressWidth'(1);
    ctr_zero    = mode64_q ? (ctr_eval == '0) : (ctr_eval[31:0] == '0);
    ctr_ok      = bo_q[2] | (ctr_zero ^ ~bo_q[3]);
    cond_ok     = bo_q[0] | (cr_q[bi_q] == bo_q[1]);
    taken_eval  = rec_ok & ctr_ok & cond_ok;
    nia         = taken_eval ? (aa_q ? exts : cia_q + exts) : cia_next;
    target_eval = !rec_ok ? cia_next
                : (mode64_q ? nia : {{(addressWidth-32){1'b0}}, nia[31:0]});
    lr_eval     = mode64_q ? cia_next : {{(addressWidth-32){1'b0}}, cia_next[31:0]};
    ctr_upd     = (state == EVAL) && rec_ok && !bo_q[2];
    lr_upd      = (state == EVAL) && rec_ok && lk_q;
  end

  // Architected registers: an EVAL update beats a coincident external write,
  // which is parked for one cycle; any newer external write supersedes it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ctr_q         <= '0;
      lr_q          <= '0;
      ctr_pend      <= 1'b0;
      lr_pend       <= 1'b0;
      ctr_pend_data <= '0;
      lr_pend_data  <= '0;
    end else begin
      if (ctr_upd) begin
        ctr_q         <= ctr_eval;
        ctr_pend      <= bus.ctrWrite_i;
        ctr_pend_data <= bus.ctrData_i;
      end else if (bus.ctrWrite_i) begin
        ctr_q    <= bus.ctrData_i;
        ctr_pend <= 1'b0;
      end else if (ctr_pend) begin
        ctr_q    <= ctr_pend_data;
        ctr_pend <= 1'b0;
      end

      if (lr_upd) begin
        lr_q         <= lr_eval;
        lr_pend      <= bus.lrWrite_i;
        lr_pend_data <= bus.lrData_i;
      end else if (bus.lrWrite_i) begin
        lr_q    <= bus.lrData_i;
        lr_pend <= 1'b0;
      end else if (lr_pend) begin
        lr_q    <= lr_pend_data;
        lr_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      taken_q   <= 1'b0;
      target_q  <= '0;
      id_out_q  <= '0;
      op_q      <= '0;
      unit_q    <= '0;
      cia_q     <= '0;
      id_q      <= '0;
      mode64_q  <= 1'b0;
      bo_q      <= '0;
      bi_q      <= '0;
      bd_q      <= '0;
      aa_q      <= 1'b0;
      lk_q      <= 1'b0;
      cr_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_q <= 1'b0;
          if (bus.enable_i) begin
            op_q     <= bus.instructionOpcode_i;
            unit_q   <= bus.functionalUnitType_i;
            cia_q    <= bus.instructionAddress_i;
            id_q     <= bus.instMajId_i;
            mode64_q <= bus.is64Bit_i;
            bo_q     <= bus.instructionBody_i[0 +: regSize];
            bi_q     <= bus.instructionBody_i[biLo +: regSize];
            bd_q     <= bus.instructionBody_i[bdLo +: bdWidth];
            aa_q     <= bus.instructionBody_i[aaPos];
            lk_q     <= bus.instructionBody_i[lkPos];
            cr_q     <= bus.condReg_i;
            busy_q   <= 1'b1;
            state    <= EVAL;
          end
        end
        EVAL: begin
          valid_q   <= 1'b1;
          invalid_q <= !rec_ok;
          taken_q   <= taken_eval;
          target_q  <= target_eval;
          id_out_q  <= id_q;
          state     <= RESP;
        end
        RESP: begin
          if (!bus.stall_i) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o      = busy_q;
  assign bus.valid_o     = valid_q;
  assign bus.invalid_o   = invalid_q;
  assign bus.taken_o     = taken_q;
  assign bus.target_o    = target_q;
  assign bus.instMajId_o = id_out_q;
  assign bus.ctr_o       = ctr_q;
  assign bus.lr_o        = lr_q;
endmodule

// File: tb/tb_branch_conditional_unit.sv
// Randomized and directed bench for branch_conditional_unit against a
// behavioural model of Branch Conditional semantics.
module tb_branch_conditional_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_conditional_unit_if bus ();

  branch_conditional_unit #(.BranchUnitID(6)) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  longint unsigned ctr_m = 0;
  longint unsigned lr_m  = 0;
  localparam longint unsigned LO32 = 64'h0000_0000_FFFF_FFFF;

  bit              obs_taken, obs_invalid;
  longint unsigned obs_target;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int bo_bit(input int bo, input int k);
    return (bo >> (4 - k)) & 1;
  endfunction

  task automatic predict(input int op, input int unit, input longint unsigned cia, input bit m64,
                         input int bo, input int bi, input int bd, input bit aa, input bit lk,
                         input int unsigned cr, output bit inv, output bit tk,
                         output longint unsigned tgt);
    longint unsigned ext, ctr_new, nia;
    bit ctr_ok, cond_ok;
    inv = (op != 16) || (unit != 6);
    tk  = 1'b0;
    tgt = cia + 4;
    if (!inv) begin
      ext     = longint'(shortint'(bd));
      ctr_new = (bo_bit(bo, 2) == 0) ? ctr_m - 1 : ctr_m;
      ctr_ok  = bo_bit(bo, 2) == 1 ||
                (((m64 ? ctr_new : (ctr_new & LO32)) != 0) != (bo_bit(bo, 3) == 1));
      cond_ok = bo_bit(bo, 0) == 1 || (((cr >> (31 - bi)) & 1) == bo_bit(bo, 1));
      tk      = ctr_ok && cond_ok;
      nia     = tk ? (aa ? ext : cia + ext) : cia + 4;
      tgt     = m64 ? nia : (nia & LO32);
      if (lk) lr_m = m64 ? cia + 4 : ((cia + 4) & LO32);
      ctr_m   = ctr_new;
    end
  endtask

  task automatic drive_record(input int op, input int unit, input longint unsigned cia, input bit m64,
                              input int bo, input int bi, input int bd, input bit aa, input bit lk,
                              input int unsigned cr, input longint unsigned id);
    logic [27:0] body;
    body = {bo[4:0], bi[4:0], bd[15:0], aa, lk};
    bus.instructionOpcode_i  = op[5:0];
    bus.functionalUnitType_i = unit[2:0];
    bus.instructionAddress_i = cia;
    bus.instMajId_i          = id;
    bus.is64Bit_i            = m64;
    bus.instructionBody_i    = body;
    bus.condReg_i            = cr;
    bus.enable_i             = 1'b1;
  endtask

  // Starts and ends on a negedge with the unit idle.
  task automatic issue(input int op, input int unit, input longint unsigned cia, input bit m64,
                       input int bo, input int bi, input int bd, input bit aa, input bit lk,
                       input int unsigned cr, input int stall_n);
    bit inv, tk;
    longint unsigned tgt, id;
    int waited;
    id = {$urandom, $urandom};
    drive_record(op, unit, cia, m64, bo, bi, bd, aa, lk, cr, id);
    bus.stall_i = (stall_n > 0);
    predict(op, unit, cia, m64, bo, bi, bd, aa, lk, cr, inv, tk, tgt);
    @(negedge clk);
    bus.enable_i = 1'b0;
    waited = 0;
    while (bus.valid_o !== 1'b1 && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    if (bus.valid_o !== 1'b1) begin
      check("valid_timeout", {63'b0, bus.valid_o}, 64'd1);
      bus.stall_i = 1'b0;
      repeat (4) @(negedge clk);
      return;
    end
    obs_taken   = bus.taken_o;
    obs_invalid = bus.invalid_o;
    obs_target  = bus.target_o;
    check("busy_resp", {63'b0, bus.busy_o}, 64'd1);
    check("invalid",   {63'b0, bus.invalid_o}, {63'b0, inv});
    check("taken",     {63'b0, bus.taken_o}, {63'b0, tk});
    check("target",    bus.target_o, tgt);
    check("majid",     bus.instMajId_o, id);
    check("ctr",       bus.ctr_o, ctr_m);
    check("lr",        bus.lr_o, lr_m);
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      check("stall_valid",  {63'b0, bus.valid_o}, 64'd1);
      check("stall_busy",   {63'b0, bus.busy_o}, 64'd1);
      check("stall_target", bus.target_o, tgt);
    end
    bus.stall_i = 1'b0;
    @(negedge clk);
    check("valid_drop", {63'b0, bus.valid_o}, 64'd0);
    check("busy_drop",  {63'b0, bus.busy_o}, 64'd0);
  endtask

  task automatic write_ctr(input longint unsigned v);
    bus.ctrWrite_i = 1'b1;
    bus.ctrData_i  = v;
    @(negedge clk);
    bus.ctrWrite_i = 1'b0;
    ctr_m = v;
    check("ctr_write", bus.ctr_o, v);
  endtask

  task automatic write_lr(input longint unsigned v);
    bus.lrWrite_i = 1'b1;
    bus.lrData_i  = v;
    @(negedge clk);
    bus.lrWrite_i = 1'b0;
    lr_m = v;
    check("lr_write", bus.lr_o, v);
  endtask

  initial begin
    longint unsigned ctr_before;
    bus.enable_i = 0; bus.stall_i = 0; bus.instructionOpcode_i = '0;
    bus.instructionAddress_i = '0; bus.functionalUnitType_i = '0; bus.instMajId_i = '0;
    bus.is64Bit_i = 1; bus.instructionBody_i = '0; bus.condReg_i = '0;
    bus.ctrWrite_i = 0; bus.ctrData_i = '0; bus.lrWrite_i = 0; bus.lrData_i = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",    {63'b0, bus.busy_o}, 64'd0);
    check("rst_valid",   {63'b0, bus.valid_o}, 64'd0);
    check("rst_invalid", {63'b0, bus.invalid_o}, 64'd0);
    check("rst_taken",   {63'b0, bus.taken_o}, 64'd0);
    check("rst_target",  bus.target_o, 64'd0);
    check("rst_majid",   bus.instMajId_o, 64'd0);
    check("rst_ctr",     bus.ctr_o, 64'd0);
    check("rst_lr",      bus.lr_o, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Decrement and branch on CTR!=0
    write_ctr(5);
    issue(16, 6, 64'h1000, 1, 5'b10000, 0, 16'h0010, 0, 0, 0, 0);
    check("t1_taken",  {63'b0, obs_taken}, 64'd1);
    check("t1_target", obs_target, 64'h1010);
    check("t1_ctr",    bus.ctr_o, 64'd4);

    write_ctr(1);
    issue(16, 6, 64'h1000, 1, 5'b10000, 0, 16'h0010, 0, 0, 0, 0);
    check("t2_taken",  {63'b0, obs_taken}, 64'd0);
    check("t2_target", obs_target, 64'h1004);
    check("t2_ctr",    bus.ctr_o, 64'd0);
    write_ctr(1);
    issue(16, 6, 64'h1000, 1, 5'b10010, 0, 16'h0010, 0, 0, 0, 0);
    check("t2b_taken", {63'b0, obs_taken}, 64'd1);

    // CR bit test, CTR untouched
    write_ctr(7);
    issue(16, 6, 64'h3000, 1, 5'b00100, 2, 16'h0040, 0, 0, 32'h2000_0000, 0);
    check("t3_taken", {63'b0, obs_taken}, 64'd0);
    check("t3_ctr",   bus.ctr_o, 64'd7);
    issue(16, 6, 64'h3000, 1, 5'b00100, 2, 16'h0040, 0, 0, 32'h0000_0000, 0);
    check("t3b_taken", {63'b0, obs_taken}, 64'd1);

    // Absolute negative target with link, both modes
    issue(16, 6, 64'h2000, 1, 5'b10100, 0, 16'hFFFC, 1, 1, 0, 0);
    check("t4_target", obs_target, 64'hFFFF_FFFF_FFFF_FFFC);
    check("t4_lr",     bus.lr_o, 64'h2004);
    issue(16, 6, 64'h2000, 0, 5'b10100, 0, 16'hFFFC, 1, 1, 0, 0);
    check("t4b_target", obs_target, 64'h0000_0000_FFFF_FFFC);

    // Rejected records, one held under stall
    issue(18, 6, 64'h4000, 1, 5'b00000, 0, 16'h0100, 0, 1, 0, 0);
    check("t5_invalid", {63'b0, obs_invalid}, 64'd1);
    issue(16, 0, 64'h4000, 1, 5'b00000, 0, 16'h0100, 0, 1, 0, 4);
    check("t5b_invalid", {63'b0, obs_invalid}, 64'd1);

    // External CTR/LR writes coincident with EVAL updating both
    write_ctr(10);
    drive_record(16, 6, 64'h5000, 1, 5'b10100, 0, 16'h0008, 0, 1, 0, 64'h55);
    bus.instructionBody_i[2] = 1'b0;  // BO=10000: decrement
    @(negedge clk);
    bus.enable_i = 1'b0;
    bus.ctrWrite_i = 1'b1; bus.ctrData_i = 64'h99;
    bus.lrWrite_i  = 1'b1; bus.lrData_i  = 64'h77;
    @(negedge clk);
    bus.ctrWrite_i = 1'b0; bus.lrWrite_i = 1'b0;
    check("t6_ctr_eval", bus.ctr_o, 64'd9);
    check("t6_lr_eval",  bus.lr_o, 64'h5004);
    check("t6_valid",    {63'b0, bus.valid_o}, 64'd1);
    @(negedge clk);
    check("t6_ctr_pend", bus.ctr_o, 64'h99);
    check("t6_lr_pend",  bus.lr_o, 64'h77);
    check("t6_idle",     {63'b0, bus.busy_o}, 64'd0);
    ctr_m = 64'h99; lr_m = 64'h77;

    // Reset while in EVAL discards the record
    drive_record(16, 6, 64'h6000, 1, 5'b10000, 0, 16'h0008, 0, 1, 0, 64'h66);
    @(negedge clk);
    bus.enable_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6r_busy",  {63'b0, bus.busy_o}, 64'd0);
    check("t6r_valid", {63'b0, bus.valid_o}, 64'd0);
    check("t6r_ctr",   bus.ctr_o, 64'd0);
    check("t6r_lr",    bus.lr_o, 64'd0);
    ctr_m = 0; lr_m = 0;
    @(negedge clk);

    for (int n = 0; n < 200; n++) begin
      int op, unit, sel;
      longint unsigned cia;
      sel = $urandom_range(0, 9);
      if (sel == 0) write_ctr(longint'($urandom_range(0, 3)));
      else if (sel == 1) write_ctr(64'h1_0000_0000 + longint'($urandom_range(0, 2)));
      else if (sel == 2) write_lr({$urandom, $urandom});
      op   = ($urandom_range(0, 9) == 0) ? 18 : 16;
      unit = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 6;
      cia  = {$urandom, $urandom} & ~64'h3;
      issue(op, unit, cia, 1'($urandom), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
            int'($urandom_range(0, 65535)) & 32'hFFFC, 1'($urandom), 1'($urandom),
            $urandom, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
